// File: rtl/fsqrt_wb_buffer_pkg.sv
// Shared FPU constants used by the fsqrt writeback buffer: IEEE-754 special
// values, writeback flag bit positions and the FP register index width.
package fpu_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_INF  = 32'h7f80_0000;
    localparam logic [31:0] FP_NAN  = 32'h7fc0_0000;

    localparam int FLG_INV = 1;
    localparam int FLG_INF = 0;

    localparam int RD_W = 5;

    // Classify a rounded root; only the canonical encodings are recognised.
    function automatic logic [1:0] sqrt_flags(input logic [31:0] s);
        logic [1:0] f;
        f          = 2'b00;
        f[FLG_INV] = (s == FP_NAN);
        f[FLG_INF] = (s == FP_INF);
        return f;
    endfunction

endpackage

// File: rtl/fsqrt_wb_buffer_if.sv
// Issue / completion / writeback signal bundle for fsqrt_wb_buffer.
// The buffer connects to the slave modport; its environment uses master.
interface fsqrt_wb_buffer_if #(parameter int PW = 1);
    import fpu_pkg::*;

    logic            issue_valid;
    logic [RD_W-1:0] issue_rd;
    logic            stall_req;
    logic            sq_done;
    logic [31:0]     sq_s;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic [1:0]      wb_flags;
    logic            wb_ready;
    logic [PW:0]     occupancy;
    logic            proto_err;

    modport slave (
        input  issue_valid, issue_rd, sq_done, sq_s, wb_ready,
        output stall_req, wb_valid, wb_rd, wb_data, wb_flags, occupancy, proto_err
    );

    modport master (
        output issue_valid, issue_rd, sq_done, sq_s, wb_ready,
        input  stall_req, wb_valid, wb_rd, wb_data, wb_flags, occupancy, proto_err
    );

endinterface

// File: rtl/fsqrt_wb_fifo.sv
// Synchronous FIFO with registered storage and async active-high clear.
// DEPTH must be a power of two so the PW-bit pointers wrap naturally.
module fsqrt_wb_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fsqrt_wb_buffer.sv
// Tags in-flight fsqrt ops with their destination register, captures results
// and feeds the FP writeback arbiter. Define FSQRT_WB_FLAGS_EN to store flags.
module fsqrt_wb_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clr,
    fsqrt_wb_buffer_if.slave      bus
);

`ifdef FSQRT_WB_FLAGS_EN
    localparam int RES_W = RD_W + 32 + 2;
`else
    localparam int RES_W = RD_W + 32;
`endif

    logic [PW:0]      tag_count, res_count, occ;
    logic [RD_W-1:0]  tag_head;
    logic [RES_W-1:0] res_din, res_head;
    logic             stall, wb_valid;
    logic             tag_push, tag_pop, res_pop;
    logic             proto_err_q, proto_err_d;

    // A completion with no tag outstanding has no destination; drop it and flag it.
    always_comb begin
        occ         = tag_count + res_count;
        stall       = (occ == (PW+1)'(DEPTH));
        wb_valid    = (res_count != '0);
        tag_push    = bus.issue_valid && !stall;
        tag_pop     = bus.sq_done && (tag_count != '0);
        res_pop     = wb_valid && bus.wb_ready;
        proto_err_d = proto_err_q || (bus.sq_done && (tag_count == '0));
    end

    fsqrt_wb_fifo #(.WIDTH(RD_W), .DEPTH(DEPTH), .PW(PW)) u_tag_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (bus.issue_rd),
        .head  (tag_head),
        .count (tag_count)
    );

    fsqrt_wb_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH), .PW(PW)) u_res_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (tag_pop),
        .pop   (res_pop),
        .din   (res_din),
        .head  (res_head),
        .count (res_count)
    );

`ifdef FSQRT_WB_FLAGS_EN
    assign res_din      = {tag_head, bus.sq_s, sqrt_flags(bus.sq_s)};
    assign bus.wb_rd    = res_head[RES_W-1 -: RD_W];
    assign bus.wb_data  = res_head[33:2];
    assign bus.wb_flags = res_head[1:0];
`else
    assign res_din      = {tag_head, bus.sq_s};
    assign bus.wb_rd    = res_head[RES_W-1 -: RD_W];
    assign bus.wb_data  = res_head[31:0];
    assign bus.wb_flags = 2'b00;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.stall_req = stall;
    assign bus.wb_valid  = wb_valid;
    assign bus.occupancy = occ;
    assign bus.proto_err = proto_err_q;

endmodule
